// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU op codes and the ID/EX instruction record.
package cpu_pkg;

  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic [2:0]         alu_control;
    logic [RADDR_W-1:0] rs_addr;
    logic [RADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    logic [DATA_W-1:0]  imm;
    logic               use_imm;
    logic [RADDR_W-1:0] rd_addr;
    logic               reg_write;
  } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding select: MEM over WB over register value. WB path only with FORWARD_WB_EN.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int RADDR_W = cpu_pkg::RADDR_W
) (
  input  logic [RADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]  reg_data,
  input  logic               mem_fwd_en,
  input  logic [RADDR_W-1:0] mem_fwd_addr,
  input  logic [DATA_W-1:0]  mem_fwd_data,
  input  logic               mem_fwd_pending,
`ifdef FORWARD_WB_EN
  input  logic               wb_fwd_en,
  input  logic [RADDR_W-1:0] wb_fwd_addr,
  input  logic [DATA_W-1:0]  wb_fwd_data,
`endif
  output logic [DATA_W-1:0]  data,
  output logic               hit,
  output logic               hazard
);

  always_comb begin
    data   = reg_data;
    hit    = 1'b0;
    hazard = 1'b0;
    // A pending MEM match blocks the older WB value: it would be stale.
    if (mem_fwd_en && (mem_fwd_addr == addr) && (addr != '0)) begin
      if (mem_fwd_pending) begin
        hazard = 1'b1;
      end else begin
        hit  = 1'b1;
        data = mem_fwd_data;
      end
    end
`ifdef FORWARD_WB_EN
    else if (wb_fwd_en && (wb_fwd_addr == addr) && (addr != '0)) begin
      hit  = 1'b1;
      data = wb_fwd_data;
    end
`endif
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID->EX register with RAW forwarding, load-use stall and flush feeding the ALU.
// Define FORWARD_WB_EN to add the WB-stage forwarding path and its wb_fwd_* ports.
module ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int RADDR_W = cpu_pkg::RADDR_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_alu_control,
  input  logic [RADDR_W-1:0] in_rs_addr,
  input  logic [RADDR_W-1:0] in_rt_addr,
  input  logic [DATA_W-1:0]  in_rs_data,
  input  logic [DATA_W-1:0]  in_rt_data,
  input  logic [DATA_W-1:0]  in_imm,
  input  logic               in_use_imm,
  input  logic [RADDR_W-1:0] in_rd_addr,
  input  logic               in_reg_write,
  input  logic               mem_fwd_en,
  input  logic [RADDR_W-1:0] mem_fwd_addr,
  input  logic [DATA_W-1:0]  mem_fwd_data,
  input  logic               mem_fwd_pending,
`ifdef FORWARD_WB_EN
  input  logic               wb_fwd_en,
  input  logic [RADDR_W-1:0] wb_fwd_addr,
  input  logic [DATA_W-1:0]  wb_fwd_data,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         alu_control,
  output logic [DATA_W-1:0]  srcA,
  output logic [DATA_W-1:0]  srcB,
  output logic [RADDR_W-1:0] out_rd_addr,
  output logic               out_reg_write
);

  logic               valid_q;
  logic [2:0]         alu_control_q;
  logic [RADDR_W-1:0] rs_addr_q, rt_addr_q, rd_addr_q;
  logic [DATA_W-1:0]  rs_data_q, rt_data_q, imm_q;
  logic               use_imm_q, reg_write_q;

  logic [DATA_W-1:0]  rs_fwd, rt_fwd;
  logic               rs_hit, rt_hit, rs_haz, rt_haz;
  logic               hazard;

  fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_rs_fwd (
    .addr            (rs_addr_q),
    .reg_data        (rs_data_q),
    .mem_fwd_en      (mem_fwd_en),
    .mem_fwd_addr    (mem_fwd_addr),
    .mem_fwd_data    (mem_fwd_data),
    .mem_fwd_pending (mem_fwd_pending),
`ifdef FORWARD_WB_EN
    .wb_fwd_en       (wb_fwd_en),
    .wb_fwd_addr     (wb_fwd_addr),
    .wb_fwd_data     (wb_fwd_data),
`endif
    .data            (rs_fwd),
    .hit             (rs_hit),
    .hazard          (rs_haz)
  );

  fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_rt_fwd (
    .addr            (rt_addr_q),
    .reg_data        (rt_data_q),
    .mem_fwd_en      (mem_fwd_en),
    .mem_fwd_addr    (mem_fwd_addr),
    .mem_fwd_data    (mem_fwd_data),
    .mem_fwd_pending (mem_fwd_pending),
`ifdef FORWARD_WB_EN
    .wb_fwd_en       (wb_fwd_en),
    .wb_fwd_addr     (wb_fwd_addr),
    .wb_fwd_data     (wb_fwd_data),
`endif
    .data            (rt_fwd),
    .hit             (rt_hit),
    .hazard          (rt_haz)
  );

  // An immediate-form instruction never reads rt, so its load-use hazard is moot.
  assign hazard        = rs_haz | (rt_haz & ~use_imm_q);
  assign out_valid     = valid_q & ~hazard;
  assign in_ready      = ~valid_q | (out_ready & ~hazard);
  assign srcA          = rs_fwd;
  assign srcB          = use_imm_q ? imm_q : rt_fwd;
  assign alu_control   = alu_control_q;
  assign out_rd_addr   = rd_addr_q;
  assign out_reg_write = reg_write_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q       <= 1'b0;
      alu_control_q <= '0;
      rs_addr_q     <= '0;
      rt_addr_q     <= '0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
      use_imm_q     <= 1'b0;
      rd_addr_q     <= '0;
      reg_write_q   <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q       <= 1'b1;
      alu_control_q <= in_alu_control;
      rs_addr_q     <= in_rs_addr;
      rt_addr_q     <= in_rt_addr;
      rs_data_q     <= in_rs_data;
      rt_data_q     <= in_rt_data;
      imm_q         <= in_imm;
      use_imm_q     <= in_use_imm;
      rd_addr_q     <= in_rd_addr;
      reg_write_q   <= in_reg_write;
    end else if (out_valid && out_ready) begin
      valid_q <= 1'b0;
    end else begin
      // Capture forwarded values while stalled; the producer may retire before we issue.
      if (rs_hit) rs_data_q <= rs_fwd;
      if (rt_hit) rt_data_q <= rt_fwd;
    end
  end

endmodule
